// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths and fetch FSM encoding for the instruction fetch controller.
package inst_fetch_ctrl_pkg;
  localparam int INST_BITS = 32;
  localparam int PC_BITS   = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// Synchronous instruction FIFO; flush clears the pointers and wins over push/pop.
module inst_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int p_depth      = 8,
  parameter int p_depth_log2 = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [INST_BITS-1:0] wdata,
  output logic [INST_BITS-1:0] rdata,
  output logic                 empty,
  output logic                 full
);
  localparam logic [p_depth_log2:0]   FULL_COUNT = (p_depth_log2+1)'(p_depth);
  localparam logic [p_depth_log2:0]   COUNT_ONE  = (p_depth_log2+1)'(1);
  localparam logic [p_depth_log2-1:0] PTR_ONE    = p_depth_log2'(1);

  logic [INST_BITS-1:0]    mem [p_depth];
  logic [p_depth_log2-1:0] wr_ptr;
  logic [p_depth_log2-1:0] rd_ptr;
  logic [p_depth_log2:0]   count;
  logic                    do_push;
  logic                    do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + COUNT_ONE;
      else if (do_pop && !do_push) count <= count - COUNT_ONE;
    end
  end

  // Storage is not reset; the read side is gated by empty in the top.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: Avalon-MM burst reads into a FIFO, redirect/flush on jumps.
//   state   | meaning
//   IDLE    | no burst outstanding; request once the FIFO drains
//   REQ     | o_read asserted, waiting for the slave to take the request
//   WAIT    | burst accepted; counting beats, pushing unless discarding
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int p_fifo_length      = 8,
  parameter int p_fifo_length_log2 = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [PC_BITS-1:0]            o_ret_addr,
  output logic                          o_ret_addr_valid,
  input  logic [PC_BITS-1:0]            i_jr_addr,
  input  logic                          i_jr_valid,
  input  logic [PC_BITS-1:0]            i_j_addr,
  input  logic                          i_j_valid,
  input  logic [PC_BITS-1:0]            i_jal_addr,
  input  logic                          i_jal_valid,
  input  logic [PC_BITS-1:0]            i_be_bne_addr,
  input  logic                          i_be_bne_valid,
  output logic [INST_BITS-1:0]          o_inst,
  output logic                          o_inst_valid,
  output logic                          o_rst_inst_fifo,
  input  logic                          i_inst_complete,
  output logic                          o_inst_empty,
  output logic [p_fifo_length_log2:0]   o_burstcount,
  output logic [31:0]                   o_addr,
  output logic                          o_read,
  input  logic                          i_waitrequest,
  input  logic [INST_BITS-1:0]          i_readdata,
  input  logic                          i_readdatavalid,
  output logic                          o_fetch_complete
);
  localparam logic [p_fifo_length_log2:0] BURST_LEN = (p_fifo_length_log2+1)'(p_fifo_length);
  localparam logic [p_fifo_length_log2:0] BEAT_ONE  = (p_fifo_length_log2+1)'(1);
  localparam logic [PC_BITS-1:0]          PC_ONE    = PC_BITS'(1);

  fetch_state_t                state, state_next;
  logic [PC_BITS-1:0]          fetch_pc, head_pc, redirect_target;
  logic                        redirect, redirect_is_jal;
  logic [p_fifo_length_log2:0] beats;
  logic                        discard;
  logic                        accept, beat, last_beat;
  logic                        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [INST_BITS-1:0]        fifo_rdata;

  always_comb begin
    redirect        = 1'b1;
    redirect_is_jal = 1'b0;
    redirect_target = '0;
    if (i_jr_valid)          redirect_target = i_jr_addr;
    else if (i_jal_valid) begin
      redirect_target = i_jal_addr;
      redirect_is_jal = 1'b1;
    end
    else if (i_j_valid)      redirect_target = i_j_addr;
    else if (i_be_bne_valid) redirect_target = i_be_bne_addr;
    else                     redirect = 1'b0;
  end

  assign accept    = (state == ST_REQ) && !i_waitrequest;
  assign beat      = (state == ST_WAIT) && i_readdatavalid;
  assign last_beat = beat && (beats == BEAT_ONE);
  assign fifo_push = beat && !discard && !redirect && !fifo_full;
  assign fifo_pop  = i_inst_complete && !fifo_empty && !redirect;

  // An accepted request cannot be withdrawn, so a same-cycle redirect still enters WAIT (discarding).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (fifo_empty) state_next = ST_REQ;
      ST_REQ: begin
        if (accept)        state_next = ST_WAIT;
        else if (redirect) state_next = ST_IDLE;
      end
      ST_WAIT: if (last_beat) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      fetch_pc         <= '0;
      head_pc          <= '0;
      beats            <= '0;
      discard          <= 1'b0;
      o_rst_inst_fifo  <= 1'b0;
      o_ret_addr       <= '0;
      o_ret_addr_valid <= 1'b0;
    end else begin
      state            <= state_next;
      o_rst_inst_fifo  <= redirect;
      o_ret_addr_valid <= redirect && redirect_is_jal;
      if (redirect && redirect_is_jal) o_ret_addr <= head_pc + PC_ONE;

      if (accept) begin
        beats   <= BURST_LEN;
        discard <= redirect;
      end else if (state == ST_WAIT) begin
        if (beat) beats <= beats - BEAT_ONE;
        if (last_beat)     discard <= 1'b0;
        else if (redirect) discard <= 1'b1;
      end

      if (redirect) begin
        fetch_pc <= redirect_target;
        head_pc  <= redirect_target;
      end else begin
        if (fifo_push) fetch_pc <= fetch_pc + PC_ONE;
        if (fifo_pop)  head_pc  <= head_pc + PC_ONE;
      end
    end
  end

  inst_fifo #(
    .p_depth      (p_fifo_length),
    .p_depth_log2 (p_fifo_length_log2)
  ) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata (i_readdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign o_read           = (state == ST_REQ);
  assign o_addr           = {12'b0, fetch_pc, 2'b00};
  assign o_burstcount     = BURST_LEN;
  assign o_inst           = fifo_empty ? '0 : fifo_rdata;
  assign o_inst_valid     = !fifo_empty;
  assign o_inst_empty     = fifo_empty;
  assign o_fetch_complete = last_beat;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus a randomized redirect soak.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] o_ret_addr;
  logic        o_ret_addr_valid;
  logic [17:0] i_jr_addr, i_j_addr, i_jal_addr, i_be_bne_addr;
  logic        i_jr_valid, i_j_valid, i_jal_valid, i_be_bne_valid;
  logic [31:0] o_inst;
  logic        o_inst_valid, o_rst_inst_fifo, i_inst_complete, o_inst_empty;
  logic [3:0]  o_burstcount;
  logic [31:0] o_addr;
  logic        o_read, i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_readdatavalid, o_fetch_complete;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  inst_fetch_ctrl #(.p_fifo_length(8), .p_fifo_length_log2(3)) dut (
    .clk(clk), .rst(rst),
    .o_ret_addr(o_ret_addr), .o_ret_addr_valid(o_ret_addr_valid),
    .i_jr_addr(i_jr_addr), .i_jr_valid(i_jr_valid),
    .i_j_addr(i_j_addr), .i_j_valid(i_j_valid),
    .i_jal_addr(i_jal_addr), .i_jal_valid(i_jal_valid),
    .i_be_bne_addr(i_be_bne_addr), .i_be_bne_valid(i_be_bne_valid),
    .o_inst(o_inst), .o_inst_valid(o_inst_valid), .o_rst_inst_fifo(o_rst_inst_fifo),
    .i_inst_complete(i_inst_complete), .o_inst_empty(o_inst_empty),
    .o_burstcount(o_burstcount), .o_addr(o_addr), .o_read(o_read),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .i_readdatavalid(i_readdatavalid), .o_fetch_complete(o_fetch_complete)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return {14'h2A5, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_jr_addr = '0; i_j_addr = '0; i_jal_addr = '0; i_be_bne_addr = '0;
    i_jr_valid = 0; i_j_valid = 0; i_jal_valid = 0; i_be_bne_valid = 0;
    i_inst_complete = 0; i_waitrequest = 0; i_readdata = '0; i_readdatavalid = 0;
  endtask

  // Ends at a negedge with o_read high when ok=1.
  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic feed_burst(input logic [31:0] first, input int n, input bit keep, input int last_idx);
    for (int i = 0; i < n; i++) begin
      i_readdatavalid = 1'b1;
      i_readdata = first + 32'(i);
      if (keep) sb_q.push_back(first + 32'(i));
      @(negedge clk);
      checks++;
      if (o_fetch_complete !== (i == last_idx)) begin
        failures++;
        $display("FAIL fetch_complete beat=%0d got=%b exp=%b", i, o_fetch_complete, (i == last_idx));
      end
      step();
    end
    i_readdatavalid = 1'b0;
    i_readdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (4) step();
    @(negedge clk);
    checks++;
    if ({o_read, o_inst_valid, o_inst_empty, o_rst_inst_fifo, o_ret_addr_valid, o_fetch_complete} !== 6'b001000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=001000",
               {o_read, o_inst_valid, o_inst_empty, o_rst_inst_fifo, o_ret_addr_valid, o_fetch_complete});
    end
    checks++;
    if (o_addr !== 32'h0 || o_inst !== 32'h0 || o_ret_addr !== 18'h0 || o_burstcount !== 4'd8) begin
      failures++;
      $display("FAIL reset_values addr=%h inst=%h ret=%h burst=%0d exp 0/0/0/8", o_addr, o_inst, o_ret_addr, o_burstcount);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_first_burst();
    bit ok;
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'h0 || o_burstcount !== 4'd8) begin
      failures++;
      $display("FAIL first_req ok=%0d addr=%h burst=%0d exp addr=0 burst=8", ok, o_addr, o_burstcount);
    end
    step();
    feed_burst(32'h10, 8, 1'b1, 7);
    @(negedge clk);
    checks++;
    if (o_inst !== 32'h10 || o_inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_head got=%h valid=%b exp=00000010 valid=1", o_inst, o_inst_valid);
    end
    step();
  endtask

  task automatic pop_checked(input string tag);
    logic [31:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
    i_inst_complete = 1'b1;
    @(negedge clk);
    checks++;
    if (o_inst !== exp || o_inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s got=%h valid=%b exp=%h", tag, o_inst, o_inst_valid, exp);
    end
    step();
    i_inst_complete = 1'b0;
  endtask

  task automatic test_pop_all();
    bit ok;
    for (int i = 0; i < 8; i++) pop_checked("pop_order");
    @(negedge clk);
    checks++;
    if (o_inst_empty !== 1'b1 || o_inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL drained empty=%b valid=%b exp empty=1 valid=0", o_inst_empty, o_inst_valid);
    end
    i_waitrequest = 1'b1;
    step();
  endtask

  task automatic test_waitrequest();
    bit ok;
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'h20) begin
      failures++;
      $display("FAIL second_req ok=%0d addr=%h exp=00000020", ok, o_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (o_read !== 1'b1 || o_addr !== 32'h20) begin
        failures++;
        $display("FAIL stall_hold read=%b addr=%h exp read=1 addr=00000020", o_read, o_addr);
      end
    end
    step();
    i_waitrequest = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (o_read !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept read=%b exp=0", o_read);
    end
    step();
  endtask

  task automatic test_jr_flush();
    bit ok;
    feed_burst(32'h20, 3, 1'b0, -1);
    @(negedge clk);
    checks++;
    if (o_inst !== 32'h20 || o_inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL partial_head got=%h valid=%b exp=00000020", o_inst, o_inst_valid);
    end
    step();
    i_jr_valid = 1'b1; i_jr_addr = 18'h100;
    i_readdatavalid = 1'b1; i_readdata = 32'hDEAD_0004;
    step();
    i_jr_valid = 1'b0; i_readdatavalid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_rst_inst_fifo !== 1'b1 || o_inst_empty !== 1'b1) begin
      failures++;
      $display("FAIL jr_flush rst_fifo=%b empty=%b exp 1/1", o_rst_inst_fifo, o_inst_empty);
    end
    step();
    feed_burst(32'h55, 4, 1'b0, 3);
    @(negedge clk);
    checks++;
    if (o_inst_empty !== 1'b1 || o_rst_inst_fifo !== 1'b0) begin
      failures++;
      $display("FAIL discard empty=%b rst_fifo=%b exp 1/0", o_inst_empty, o_rst_inst_fifo);
    end
    step();
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'h400) begin
      failures++;
      $display("FAIL jr_refetch ok=%0d addr=%h exp=00000400", ok, o_addr);
    end
    step();
  endtask

  task automatic test_jal();
    bit ok;
    feed_burst(32'h60, 2, 1'b0, -1);
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (o_inst_empty !== 1'b1 || o_addr !== 32'h0 || o_read !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset empty=%b addr=%h read=%b exp 1/0/0", o_inst_empty, o_addr, o_read);
    end
    step();
    rst = 1'b0;
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_req ok=%0d addr=%h exp=00000000", ok, o_addr);
    end
    step();
    feed_burst(32'hA0, 8, 1'b1, 7);
    pop_checked("jal_pop");
    pop_checked("jal_pop");
    i_inst_complete = 1'b1;
    i_jal_valid = 1'b1; i_jal_addr = 18'h40;
    step();
    i_inst_complete = 1'b0; i_jal_valid = 1'b0;
    i_waitrequest = 1'b1;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (o_ret_addr_valid !== 1'b1 || o_ret_addr !== 18'h3 || o_rst_inst_fifo !== 1'b1 || o_inst_empty !== 1'b1) begin
      failures++;
      $display("FAIL jal_ret valid=%b ret=%h rst_fifo=%b empty=%b exp 1/00003/1/1",
               o_ret_addr_valid, o_ret_addr, o_rst_inst_fifo, o_inst_empty);
    end
    step();
    @(negedge clk);
    checks++;
    if (o_ret_addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL jal_pulse valid=%b exp=0", o_ret_addr_valid);
    end
    step();
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'h100) begin
      failures++;
      $display("FAIL jal_refetch ok=%0d addr=%h exp=00000100", ok, o_addr);
    end
    step();
  endtask

  task automatic test_priority();
    bit ok;
    i_jr_valid = 1'b1; i_jr_addr = 18'h50;
    i_j_valid = 1'b1;  i_j_addr = 18'h60;
    step();
    i_jr_valid = 1'b0; i_j_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_read !== 1'b0 || o_rst_inst_fifo !== 1'b1 || o_ret_addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL req_redirect read=%b rst_fifo=%b ret_valid=%b exp 0/1/0", o_read, o_rst_inst_fifo, o_ret_addr_valid);
    end
    step();
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'h140) begin
      failures++;
      $display("FAIL jr_over_j ok=%0d addr=%h exp=00000140", ok, o_addr);
    end
    step();
    i_jal_valid = 1'b1; i_jal_addr = 18'h70;
    i_j_valid = 1'b1;   i_j_addr = 18'h60;
    i_be_bne_valid = 1'b1; i_be_bne_addr = 18'h90;
    step();
    i_jal_valid = 1'b0; i_j_valid = 1'b0; i_be_bne_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ret_addr_valid !== 1'b1 || o_ret_addr !== 18'h51) begin
      failures++;
      $display("FAIL jal_over_j valid=%b ret=%h exp 1/00051", o_ret_addr_valid, o_ret_addr);
    end
    step();
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'h1C0) begin
      failures++;
      $display("FAIL jal_target ok=%0d addr=%h exp=000001c0", ok, o_addr);
    end
    step();
    i_be_bne_valid = 1'b1; i_be_bne_addr = 18'h33;
    step();
    i_be_bne_valid = 1'b0;
    wait_read(ok);
    checks++;
    if (!ok || o_addr !== 32'hCC) begin
      failures++;
      $display("FAIL be_target ok=%0d addr=%h exp=000000cc", ok, o_addr);
    end
    step();
  endtask

  task automatic test_random_redirects();
    logic [17:0] head_model;
    logic [17:0] slave_q[$];
    head_model = 18'h33;
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_waitrequest = ($urandom_range(0, 3) == 0);
      if (slave_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        i_readdatavalid = 1'b1;
        i_readdata = mem_word(slave_q[0]);
      end else begin
        i_readdatavalid = 1'b0;
        i_readdata = '0;
      end
      i_jr_valid = ($urandom_range(0, 15) == 0);
      i_jr_addr = 18'($urandom);
      i_inst_complete = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ($isunknown({o_inst, o_addr, o_read, o_inst_valid, o_inst_empty, o_rst_inst_fifo,
                      o_ret_addr, o_ret_addr_valid, o_fetch_complete, o_burstcount})) begin
        failures++;
        $display("FAIL rand_xcheck cycle=%0d inst=%h addr=%h", cyc, o_inst, o_addr);
      end
      checks++;
      if (o_read === 1'b1 && slave_q.size() > 0) begin
        failures++;
        $display("FAIL rand_overlap cycle=%0d pending=%0d exp=0", cyc, slave_q.size());
      end
      if (o_inst_valid === 1'b1) begin
        checks++;
        if (o_inst !== mem_word(head_model)) begin
          failures++;
          $display("FAIL rand_head cycle=%0d got=%h exp=%h", cyc, o_inst, mem_word(head_model));
        end
      end
      if (o_read === 1'b1 && !i_waitrequest)
        for (int k = 0; k < 8; k++) slave_q.push_back(o_addr[19:2] + 18'(k));
      if (i_readdatavalid) void'(slave_q.pop_front());
      if (i_jr_valid) head_model = i_jr_addr;
      else if (i_inst_complete && o_inst_valid === 1'b1) head_model = head_model + 18'd1;
      step();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_first_burst();
    test_pop_all();
    test_waitrequest();
    test_jr_flush();
    test_jal();
    test_priority();
    test_random_redirects();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
